// File: rtl/mem_copy_engine.sv
`default_nettype none
// ============================================================================
//  Module      : mem_copy_engine
//  Description : Byte-wide block copy master for the data_mem port. Reads len
//                bytes from an ascending source region and writes them to an
//                ascending destination region, one byte per RD/(WT)/WR pass.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_copy_engine #(
    parameter int READ_LAT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] src_addr,
    input  logic [7:0] dst_addr,
    input  logic [7:0] len,
    output logic       busy,
    output logic       done,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       mem_r_w,
    input  logic [7:0] mem_rdata
);

    localparam logic [2:0] c_idle = 3'd0;
    localparam logic [2:0] c_rd   = 3'd1;
    localparam logic [2:0] c_wt   = 3'd2;
    localparam logic [2:0] c_wr   = 3'd3;
    localparam logic [2:0] c_fin  = 3'd4;

    logic [2:0] r_state;
    logic [2:0] w_state_nxt;

    logic [7:0] r_src;
    logic [7:0] r_dst;
    logic [7:0] r_len;
    logic [7:0] r_idx;
    logic [7:0] r_buf;

    logic       r_busy;
    logic       r_done;
    logic       r_mem_r_w;
    logic [7:0] r_mem_addr;

    logic       w_busy_nxt;
    logic       w_done_nxt;
    logic       w_mem_r_w_nxt;
    logic [7:0] w_mem_addr_nxt;

    logic       w_accept;
    logic [7:0] w_idx_inc;

    assign w_accept  = (r_state == c_idle) && start && (len != 8'd0);
    assign w_idx_inc = r_idx + 8'd1;

    // The write data bus is the byte buffer itself; it only changes on entry
    // to WR, so it naturally holds its last value in IDLE and FIN.
    assign busy      = r_busy;
    assign done      = r_done;
    assign mem_r_w   = r_mem_r_w;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_buf;

    // State register together with the registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= c_idle;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_mem_r_w  <= 1'b0;
            r_mem_addr <= 8'h00;
        end else begin
            r_state    <= w_state_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_mem_r_w  <= w_mem_r_w_nxt;
            r_mem_addr <= w_mem_addr_nxt;
        end
    end

    // Next-state decode; WT is skipped entirely for a zero-latency memory
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_idle: begin
                if (start) begin
                    w_state_nxt = (len != 8'd0) ? c_rd : c_fin;
                end
            end
            c_rd:    w_state_nxt = (READ_LAT == 0) ? c_wr : c_wt;
            c_wt:    w_state_nxt = c_wr;
            c_wr:    w_state_nxt = (w_idx_inc == r_len) ? c_fin : c_rd;
            c_fin:   w_state_nxt = c_idle;
            default: w_state_nxt = c_idle;
        endcase
    end

    // Output decode from the upcoming state so every output is a flop
    always_comb begin
        w_busy_nxt     = (w_state_nxt == c_rd) || (w_state_nxt == c_wt) ||
                         (w_state_nxt == c_wr);
        w_done_nxt     = (w_state_nxt == c_fin);
        w_mem_r_w_nxt  = (w_state_nxt == c_wr);
        w_mem_addr_nxt = r_mem_addr;
        case (w_state_nxt)
            // RD is entered either fresh from IDLE (index 0) or from WR
            // with the index about to advance.
            c_rd:    w_mem_addr_nxt = (r_state == c_idle) ? src_addr
                                                          : (r_src + w_idx_inc);
            c_wr:    w_mem_addr_nxt = r_dst + r_idx;
            default: w_mem_addr_nxt = r_mem_addr;
        endcase
    end

    // Copy context: latched on acceptance, index advances after each write,
    // read data captured on the edge that enters WR
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_src <= 8'h00;
            r_dst <= 8'h00;
            r_len <= 8'h00;
            r_idx <= 8'h00;
            r_buf <= 8'h00;
        end else begin
            if (w_accept) begin
                r_src <= src_addr;
                r_dst <= dst_addr;
                r_len <= len;
                r_idx <= 8'h00;
            end else if ((r_state == c_wr) && (w_state_nxt == c_rd)) begin
                r_idx <= w_idx_inc;
            end
            if (w_state_nxt == c_wr) begin
                r_buf <= mem_rdata;
            end
        end
    end

endmodule
`default_nettype wire
